// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
package wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 64;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   wdata;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard: stalls issue on RAW/WAW against outstanding long-unit results.
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              iss_long,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  output logic              iss_stall
);

  logic [31:1] pending;
  logic [31:0] pend_full;
  logic [31:1] set_vec;
  logic [31:1] clr_vec;
  logic        hazard;
  logic        set_en;

  // x0 never holds a pending result, so bit 0 reads as constant zero
  assign pend_full = {pending, 1'b0};
  assign hazard    = pend_full[iss_rs1] | pend_full[iss_rs2] | pend_full[iss_rd];
  assign iss_stall = iss_valid & hazard;
  assign set_en    = iss_valid & iss_long & ~iss_stall & (iss_rd != '0);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 1; i < 32; i++) begin
      set_vec[i] = set_en && (iss_rd == REG_AW'(i));
      clr_vec[i] = clr_en && (clr_addr == REG_AW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending | set_vec) & ~clr_vec;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipe writeback has priority, long-unit results wait in a
// one-entry buffer and drain on idle cycles; a starvation counter forces a writeback bubble.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_waddr,
  input  logic [XLEN-1:0]   pipe_wdata,
  input  logic              lu_valid,
  input  logic [REG_AW-1:0] lu_waddr,
  input  logic [XLEN-1:0]   lu_wdata,
  output logic              lu_ready,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              iss_long,
  output logic              iss_stall,
  output logic              wb_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STARVE_MAX);

  wb_req_t       pipe_req;
  wb_req_t       buf_q;
  wb_req_t       rf_req;
  logic [CW-1:0] wait_cnt;
  logic          drain;
  logic          accept;
  logic          blocked;

  assign pipe_req.we    = pipe_we;
  assign pipe_req.waddr = pipe_waddr;
  assign pipe_req.wdata = pipe_wdata;

  // The pipe wins even if it ignores wb_stall
  always_comb begin
    rf_req = '0;
    if (pipe_req.we)    rf_req = pipe_req;
    else if (buf_q.we)  rf_req = buf_q;
    if (!rst_n)         rf_req.we = 1'b0;
  end

  assign rf_we    = rf_req.we;
  assign rf_waddr = rf_req.waddr;
  assign rf_wdata = rf_req.wdata;

  assign drain    = rst_n & ~pipe_we & buf_q.we;
  assign lu_ready = rst_n & (~buf_q.we | drain);
  assign accept   = lu_valid & lu_ready;
  assign blocked  = buf_q.we & pipe_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q    <= '0;
      wait_cnt <= '0;
      wb_stall <= 1'b0;
    end else begin
      if (accept) begin
        buf_q.we    <= 1'b1;
        buf_q.waddr <= lu_waddr;
        buf_q.wdata <= lu_wdata;
      end else if (drain) begin
        buf_q.we <= 1'b0;
      end

      // Saturate so a pipe that ignores wb_stall cannot wrap the counter
      if (blocked) begin
        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (blocked && (wait_cnt == CNT_LAST)) wb_stall <= 1'b1;
      else if (drain)                        wb_stall <= 1'b0;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_long  (iss_long),
    .clr_en    (drain),
    .clr_addr  (buf_q.waddr),
    .iss_stall (iss_stall)
  );

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback and the long-latency unit (multiply/divide, misses). It holds one long-unit result in a holding buffer and drains it on idle pipeline write cycles. A starvation counter forces a writeback bubble when the buffer waits too long. A 32-entry pending scoreboard stalls issue of instructions that depend on an outstanding long-unit destination (RAW) or would overwrite one (WAW).

## Interface
- STARVE_MAX, 4, consecutive blocked cycles before a writeback bubble is forced; legal range 1..15.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- pipe_we / pipe_waddr / pipe_wdata  in  1/5/64  pipeline writeback request; never refused
- lu_valid / lu_waddr / lu_wdata  in  1/5/64  long-unit result offer
- lu_ready  out  1  long-unit result accepted when lu_valid & lu_ready
- iss_valid  in  1  instruction in issue stage
- iss_rs1 / iss_rs2 / iss_rd  in  5/5/5  issuing instruction's sources and destination
- iss_long  in  1  issuing instruction is dispatched to the long unit
- iss_stall  out  1  hold the issue stage this cycle
- wb_stall  out  1  registered; pipeline must present pipe_we=0 while high
- rf_we / rf_waddr / rf_wdata  out  1/5/64  register-file write port

## Operation
- State:
  - buf_valid, buf_waddr, buf_wdata: one-entry holding buffer.
  - pending[31:1]: scoreboard; bit 0 is hardwired 0.
  - wait_cnt: $clog2(STARVE_MAX+1) bits.
  - wb_stall flop.
- Write-port mux (combinational):
  - If pipe_we=1, the port carries the pipe request.
  - Else if buf_valid=1, the port carries the buffer. This is a drain.
  - Else rf_we=0.
  - The pipe has absolute priority. If pipe_we=1 while wb_stall=1 (protocol violation), the pipe still wins.
- Buffer:
  - lu_ready = ~buf_valid | drain.
  - On accept: buf_valid←1 and the address/data are captured. Accept and drain in the same cycle keeps buf_valid=1 with the new contents.
  - Drain without accept: buf_valid←0.
  - lu_waddr=0 is accepted and drained with rf_we=1. Zero-address discard is left to the regfile.
- Starvation:
  - A cycle is blocked when buf_valid & pipe_we.
  - A blocked cycle increments wait_cnt. A drain or an empty buffer clears it.
  - A blocked cycle with wait_cnt == STARVE_MAX-1 sets wb_stall←1.
  - wb_stall←0 on the cycle of the drain.
- Scoreboard:
  - Hazard if any of the following is true, where r≠0:
    - pending[iss_rs1]
    - pending[iss_rs2]
    - pending[iss_rd]
  - iss_stall = iss_valid & hazard. Stall applies to all instructions, long or not.
  - Set: iss_valid & iss_long & ~iss_stall & iss_rd≠0 sets pending[iss_rd].
  - Clear: a drain clears pending[buf_waddr].
  - The WAW stall guarantees that set and clear never target the same bit in one cycle. Both operations on different bits occur together.
  - pending is not cleared by pipeline flushes. Long ops are non-speculative once dispatched.
- Reset (rst_n=0 at a clk edge):
  - buf_valid=0, pending=0, wait_cnt=0, wb_stall=0.
  - While rst_n=0, lu_ready=0 and rf_we=0 are forced combinationally.
  - Reset mid-operation discards a buffered result.

## Timing
- Pipe write: zero latency; pipe_* reach rf_* in the same cycle.
- Long-unit result: accepted at edge N and written to the regfile no earlier than cycle N+1, i.e. on the first cycle with pipe_we=0.
- Scoreboard visibility:
  - A bit set at edge N stalls dependents from cycle N+1.
  - A bit cleared by a drain in cycle M stops stalling from cycle M+1. The regfile bypass covers the value.
- Starvation bound: a buffered result waits at most STARVE_MAX blocked cycles plus 1 bubble cycle.
- Back-to-back long results sustain 1 per cycle while pipe_we=0.

## Structure
- A shared package holds:
  - REG_AW=5, XLEN=64.
  - The wb_req_t struct {we, waddr, wdata} used for the pipe, buffer and rf port.
- One natural sub-module: wb_scoreboard, holding the pending vector, hazard compare and set/clear logic. The buffer, mux and starvation counter stay in wb_arbiter.

## Test plan
- Idle pipe: lu offers x5=0xDEAD at cycle 0 → lu_ready=1; rf_we=1, waddr=5, wdata=0xDEAD at cycle 1; pending[5] drops at cycle 2.
- Conflict: buffer holds x7 and pipe writes x3 for 2 cycles → rf carries x3 both cycles, lu_ready=0; x7 is written on the first pipe_we=0 cycle.
- Starvation: pipe_we held 1 with STARVE_MAX=4 → wb_stall=1 after the 4th blocked cycle. Bench then drops pipe_we → x7 is written, and wb_stall=0 next cycle.
- RAW/WAW: issue long rd=x10, then add rs1=x10, then add rd=x10 → both held with iss_stall=1 until the cycle after x10 drains. An instruction with rs1=x0 is never stalled.
- Throughput: pipe idle and lu_valid held with x1,x2,x3 on consecutive cycles → lu_ready stays 1, and rf writes x1,x2,x3 on consecutive cycles.
- Reset mid-operation: buffer full, pending[9]=1, wb_stall=1, rst_n=0 for one edge → all state is zero, lu_ready=0 and rf_we=0 during reset, and the x9 write is lost.
